// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register stage downstream of the 8-bit ALU.
//
// Latches ALU Z/N/C/V into architectural flags under a per-opcode update
// mask, feeds the held carry back to the ALU, evaluates branch conditions
// and saves/restores flags on interrupt entry/return.
//
// Optional feature macro: CCR_SHADOW_STACK_EN
//   undefined : single-entry shadow register
//   defined   : LIFO shadow of SHADOW_DEPTH entries (2..8)
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ex_valid          ALU result belongs to a live instruction
//   stall             blocks all state updates (except rst)
//   flush             squashes this cycle's ALU update
//   alu_sel[3:0]      ALU opcode selecting the flag update mask
//   alu_z/n/c/v       ALU combinational flag outputs
//   ccr_wr_en         explicit flag load (POP CCR)
//   ccr_wr_data[3:0]  {V,C,N,Z} for the explicit load
//   int_save          interrupt entry: push flags to shadow
//   rti_restore       return from interrupt: pop shadow into flags
//   br_cond[2:0]      branch condition selector
//   flags_q[3:0]      registered {V,C,N,Z}
//   carry_to_alu      registered carry, drives ALU cin
//   br_taken          combinational branch decision from flags_q
//   shadow_valid      shadow holds at least one entry
//   ccr_err           one-cycle pulse after an illegal save/restore
module ccr_unit #(
    parameter logic [3:0]  RESET_FLAGS  = 4'b0000,
    parameter int unsigned SHADOW_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] alu_sel,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       ccr_wr_en,
    input  logic [3:0] ccr_wr_data,
    input  logic       int_save,
    input  logic       rti_restore,
    input  logic [2:0] br_cond,
    output logic [3:0] flags_q,
    output logic       carry_to_alu,
    output logic       br_taken,
    output logic       shadow_valid,
    output logic       ccr_err
);

    if (SHADOW_DEPTH < 2 || SHADOW_DEPTH > 8) begin : g_bad_depth
        $error("ccr_unit: SHADOW_DEPTH must be in 2..8");
    end

    logic [3:0] upd_mask;
    logic [3:0] alu_flags;
    logic [3:0] flags_next;
    logic [3:0] shadow_top;
    logic       alu_upd;
    logic       do_restore;
    logic       do_save;
    logic       err_save;
    logic       err_next;

    // Mask bits ordered {V,C,N,Z}
    always_comb begin
        upd_mask = 4'b0000;
        case (alu_sel)
            4'b0010, 4'b0011, 4'b1100, 4'b1101: upd_mask = 4'b1111;
            4'b0100, 4'b0101, 4'b1010, 4'b1011: upd_mask = 4'b0011;
            4'b0110, 4'b0111, 4'b1000, 4'b1001: upd_mask = 4'b0100;
            default:                            upd_mask = 4'b0000;
        endcase
    end

    assign alu_flags  = {alu_v, alu_c, alu_n, alu_z};
    assign alu_upd    = ex_valid && !stall && !flush;
    assign do_restore = rti_restore && !stall;
    // A save coinciding with a restore is discarded (and flagged below).
    assign do_save    = int_save && !rti_restore && !stall;

    // A restore owns the cycle even when the shadow is empty, so a
    // concurrent explicit load or ALU update is dropped in that case too.
    always_comb begin
        flags_next = flags_q;
        if (do_restore) begin
            if (shadow_valid) flags_next = shadow_top;
        end else if (ccr_wr_en && !stall) begin
            flags_next = ccr_wr_data;
        end else if (alu_upd) begin
            flags_next = (flags_q & ~upd_mask) | (alu_flags & upd_mask);
        end
    end

`ifdef CCR_SHADOW_STACK_EN
    localparam int unsigned PTR_W = $clog2(SHADOW_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(SHADOW_DEPTH);

    logic [3:0]       shadow_mem [SHADOW_DEPTH];
    logic [PTR_W-1:0] shadow_ptr;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic             shadow_full;

    // top_idx wraps when the stack is empty; only used when shadow_valid.
    assign top_idx      = IDX_W'(shadow_ptr - 1'b1);
    assign push_idx     = IDX_W'(shadow_ptr);
    assign shadow_valid = (shadow_ptr != '0);
    assign shadow_full  = (shadow_ptr == PTR_W'(SHADOW_DEPTH));
    assign shadow_top   = shadow_mem[top_idx];
    assign err_save     = do_save && shadow_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_ptr <= '0;
            for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
                shadow_mem[i] <= '0;
            end
        end else if (do_restore) begin
            if (shadow_valid) shadow_ptr <= shadow_ptr - 1'b1;
        end else if (do_save && !shadow_full) begin
            shadow_mem[push_idx] <= flags_next;
            shadow_ptr           <= shadow_ptr + 1'b1;
        end
    end
`else
    logic [3:0] shadow_q;
    logic       shadow_v;

    assign shadow_valid = shadow_v;
    assign shadow_top   = shadow_q;
    assign err_save     = do_save && shadow_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            shadow_v <= 1'b0;
        end else if (do_restore) begin
            shadow_v <= 1'b0;
        end else if (do_save) begin
            shadow_q <= flags_next;
            shadow_v <= 1'b1;
        end
    end
`endif

    assign err_next = (do_restore && (!shadow_valid || int_save)) || err_save;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= RESET_FLAGS;
            ccr_err <= 1'b0;
        end else begin
            flags_q <= flags_next;
            ccr_err <= err_next;
        end
    end

    assign carry_to_alu = flags_q[2];

    always_comb begin
        br_taken = 1'b0;
        case (br_cond)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = flags_q[0];
            3'b010:  br_taken = flags_q[1];
            3'b011:  br_taken = flags_q[2];
            3'b100:  br_taken = flags_q[3];
            3'b101:  br_taken = !flags_q[0];
            3'b110:  br_taken = !flags_q[2];
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic       stall;
    logic       flush;
    logic [3:0] alu_sel;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic       ccr_wr_en;
    logic [3:0] ccr_wr_data;
    logic       int_save;
    logic       rti_restore;
    logic [2:0] br_cond;
    logic [3:0] flags_q;
    logic       carry_to_alu;
    logic       br_taken;
    logic       shadow_valid;
    logic       ccr_err;

    int n_checks = 0;
    int n_fail   = 0;

    ccr_unit #(.RESET_FLAGS(4'b0000), .SHADOW_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .flush(flush),
        .alu_sel(alu_sel), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .ccr_wr_en(ccr_wr_en), .ccr_wr_data(ccr_wr_data), .int_save(int_save),
        .rti_restore(rti_restore), .br_cond(br_cond), .flags_q(flags_q),
        .carry_to_alu(carry_to_alu), .br_taken(br_taken),
        .shadow_valid(shadow_valid), .ccr_err(ccr_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 0; ex_valid = 0; stall = 0; flush = 0; alu_sel = 4'b0000;
        alu_z = 0; alu_n = 0; alu_c = 0; alu_v = 0;
        ccr_wr_en = 0; ccr_wr_data = 4'b0000; int_save = 0; rti_restore = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one ALU op (vcnz = {V,C,N,Z} from the ALU) for one edge
    task automatic alu_op(input logic [3:0] op, input logic [3:0] vcnz);
        ex_valid = 1; alu_sel = op;
        {alu_v, alu_c, alu_n, alu_z} = vcnz;
        cycle();
        idle();
    endtask

    task automatic set_flags(input logic [3:0] v);
        ccr_wr_en = 1; ccr_wr_data = v;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; stall = 1; ccr_wr_en = 1; ccr_wr_data = 4'b1111;
        cycle();
        idle();
        n_checks++; if (flags_q !== 4'b0000) begin $display("FAIL reset_flags: got %b expected %b", flags_q, 4'b0000); n_fail++; end
        n_checks++; if (shadow_valid !== 1'b0) begin $display("FAIL reset_shadow_valid: got %b expected 0", shadow_valid); n_fail++; end
        n_checks++; if (ccr_err !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", ccr_err); n_fail++; end
        n_checks++; if (carry_to_alu !== 1'b0) begin $display("FAIL reset_carry: got %b expected 0", carry_to_alu); n_fail++; end
    endtask

    task automatic test_alu_all();
        alu_op(4'b0010, 4'b0101);   // ADD: Z=1 C=1
        n_checks++; if (flags_q !== 4'b0101) begin $display("FAIL add_flags: got %b expected %b", flags_q, 4'b0101); n_fail++; end
        n_checks++; if (carry_to_alu !== 1'b1) begin $display("FAIL add_carry: got %b expected 1", carry_to_alu); n_fail++; end
        alu_op(4'b0011, 4'b1010);   // SUB
        n_checks++; if (flags_q !== 4'b1010) begin $display("FAIL sub_flags: got %b expected %b", flags_q, 4'b1010); n_fail++; end
        alu_op(4'b1101, 4'b0110);   // DEC
        n_checks++; if (flags_q !== 4'b0110) begin $display("FAIL dec_flags: got %b expected %b", flags_q, 4'b0110); n_fail++; end
    endtask

    task automatic test_mask();
        set_flags(4'b1111);
        alu_op(4'b0100, 4'b0000);   // AND: only Z,N
        n_checks++; if (flags_q !== 4'b1100) begin $display("FAIL and_mask: got %b expected %b", flags_q, 4'b1100); n_fail++; end
        alu_op(4'b0001, 4'b0011);   // PASS: no flags
        n_checks++; if (flags_q !== 4'b1100) begin $display("FAIL pass_hold: got %b expected %b", flags_q, 4'b1100); n_fail++; end
        alu_op(4'b0111, 4'b1011);   // RRC: only C (alu C=0)
        n_checks++; if (flags_q !== 4'b1000) begin $display("FAIL rrc_mask: got %b expected %b", flags_q, 4'b1000); n_fail++; end
        alu_op(4'b1111, 4'b0111);   // unused opcode: no flags
        n_checks++; if (flags_q !== 4'b1000) begin $display("FAIL op1111_hold: got %b expected %b", flags_q, 4'b1000); n_fail++; end
        alu_op(4'b1011, 4'b0111);   // NEG: Z,N only
        n_checks++; if (flags_q !== 4'b1011) begin $display("FAIL neg_mask: got %b expected %b", flags_q, 4'b1011); n_fail++; end
    endtask

    task automatic test_block();
        set_flags(4'b0000);
        flush = 1; alu_op(4'b0010, 4'b1111);
        n_checks++; if (flags_q !== 4'b0000) begin $display("FAIL flush_hold: got %b expected %b", flags_q, 4'b0000); n_fail++; end
        stall = 1; alu_op(4'b0010, 4'b1111);
        n_checks++; if (flags_q !== 4'b0000) begin $display("FAIL stall_hold: got %b expected %b", flags_q, 4'b0000); n_fail++; end
        alu_sel = 4'b0010; ex_valid = 1; {alu_v, alu_c, alu_n, alu_z} = 4'b0101; // ADD alongside explicit load
        set_flags(4'b1010);
        n_checks++; if (flags_q !== 4'b1010) begin $display("FAIL wr_over_alu: got %b expected %b", flags_q, 4'b1010); n_fail++; end
        ex_valid = 0; alu_op(4'b0010, 4'b1111);
        alu_op(4'b0000, 4'b0000);
        n_checks++; if (flags_q !== 4'b1111) begin $display("FAIL invalid_then_add: got %b expected %b", flags_q, 4'b1111); n_fail++; end
    endtask

    task automatic test_shadow();
        set_flags(4'b0001);
        int_save = 1; alu_op(4'b1000, 4'b0100);  // SETC with save
        n_checks++; if (flags_q !== 4'b0101) begin $display("FAIL setc_save_flags: got %b expected %b", flags_q, 4'b0101); n_fail++; end
        n_checks++; if (shadow_valid !== 1'b1) begin $display("FAIL save_valid: got %b expected 1", shadow_valid); n_fail++; end
        n_checks++; if (ccr_err !== 1'b0) begin $display("FAIL save_err: got %b expected 0", ccr_err); n_fail++; end
        alu_op(4'b1001, 4'b0000);                 // CLRC
        n_checks++; if (flags_q !== 4'b0001) begin $display("FAIL clrc_flags: got %b expected %b", flags_q, 4'b0001); n_fail++; end
        rti_restore = 1; cycle(); idle();
        n_checks++; if (flags_q !== 4'b0101) begin $display("FAIL restore_flags: got %b expected %b", flags_q, 4'b0101); n_fail++; end
        n_checks++; if (shadow_valid !== 1'b0) begin $display("FAIL restore_valid: got %b expected 0", shadow_valid); n_fail++; end
        n_checks++; if (ccr_err !== 1'b0) begin $display("FAIL restore_err: got %b expected 0", ccr_err); n_fail++; end
    endtask

    task automatic test_errors();
        set_flags(4'b0110);
        // Restore from empty shadow, with a competing explicit load
        rti_restore = 1; ccr_wr_en = 1; ccr_wr_data = 4'b1001; cycle(); idle();
        n_checks++; if (flags_q !== 4'b0110) begin $display("FAIL empty_restore_flags: got %b expected %b", flags_q, 4'b0110); n_fail++; end
        n_checks++; if (ccr_err !== 1'b1) begin $display("FAIL empty_restore_err: got %b expected 1", ccr_err); n_fail++; end
        cycle();
        n_checks++; if (ccr_err !== 1'b0) begin $display("FAIL err_one_cycle: got %b expected 0", ccr_err); n_fail++; end
        // Stalled restore from empty: no error, no change
        stall = 1; rti_restore = 1; cycle(); idle();
        n_checks++; if (ccr_err !== 1'b0) begin $display("FAIL stall_restore_err: got %b expected 0", ccr_err); n_fail++; end
        stall = 1; int_save = 1; cycle(); idle();
        n_checks++; if (shadow_valid !== 1'b0) begin $display("FAIL stall_save_valid: got %b expected 0", shadow_valid); n_fail++; end
`ifndef CCR_SHADOW_STACK_EN
        int_save = 1; set_flags(4'b0011);        // save sees flags_next = 0011
        int_save = 1; set_flags(4'b1000);        // overwrite
        n_checks++; if (ccr_err !== 1'b1) begin $display("FAIL overwrite_err: got %b expected 1", ccr_err); n_fail++; end
        set_flags(4'b0000);
        rti_restore = 1; cycle(); idle();
        n_checks++; if (flags_q !== 4'b1000) begin $display("FAIL overwrite_restore: got %b expected %b", flags_q, 4'b1000); n_fail++; end
`endif
        // Save and restore together: restore wins, save dropped, error
        int_save = 1; set_flags(4'b1110);
        set_flags(4'b0001);
        int_save = 1; rti_restore = 1; cycle(); idle();
        n_checks++; if (flags_q !== 4'b1110) begin $display("FAIL save_restore_flags: got %b expected %b", flags_q, 4'b1110); n_fail++; end
        n_checks++; if (ccr_err !== 1'b1) begin $display("FAIL save_restore_err: got %b expected 1", ccr_err); n_fail++; end
        n_checks++; if (shadow_valid !== 1'b0) begin $display("FAIL save_restore_valid: got %b expected 0", shadow_valid); n_fail++; end
    endtask

`ifdef CCR_SHADOW_STACK_EN
    task automatic test_stack();
        logic [3:0] vals [5];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000; vals[4] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int_save = 1; set_flags(vals[i]);
            n_checks++; if (ccr_err !== (i == 4)) begin $display("FAIL push%0d_err: got %b expected %b", i, ccr_err, (i == 4)); n_fail++; end
        end
        for (int i = 3; i >= 0; i--) begin
            rti_restore = 1; cycle(); idle();
            n_checks++; if (flags_q !== vals[i]) begin $display("FAIL pop%0d_flags: got %b expected %b", i, flags_q, vals[i]); n_fail++; end
        end
        n_checks++; if (shadow_valid !== 1'b0) begin $display("FAIL stack_empty_valid: got %b expected 0", shadow_valid); n_fail++; end
        rti_restore = 1; cycle(); idle();
        n_checks++; if (ccr_err !== 1'b1) begin $display("FAIL stack_underflow_err: got %b expected 1", ccr_err); n_fail++; end
    endtask
`endif

    task automatic test_branch();
        logic [7:0] exp;
        set_flags(4'b0101);
        exp = 8'b0000_1011;
        for (int i = 0; i < 8; i++) begin
            br_cond = 3'(i); #1;
            n_checks++; if (br_taken !== exp[i]) begin $display("FAIL br_0101_cond%0d: got %b expected %b", i, br_taken, exp[i]); n_fail++; end
        end
        set_flags(4'b1010);
        exp = 8'b0111_0101;
        for (int i = 0; i < 8; i++) begin
            br_cond = 3'(i); #1;
            n_checks++; if (br_taken !== exp[i]) begin $display("FAIL br_1010_cond%0d: got %b expected %b", i, br_taken, exp[i]); n_fail++; end
        end
    endtask

    initial begin
        idle();
        br_cond = 3'b000;
        test_reset();
        test_alu_all();
        test_mask();
        test_block();
        test_shadow();
        test_errors();
`ifdef CCR_SHADOW_STACK_EN
        test_stack();
`endif
        test_branch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
